polytop_seq: RTL

POLYTOP_SEQ -- requirements
Module: polytop_seq

---
 rtl/polytop_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/polytop_seq.sv
// polytop_seq: group/stage/polynomial issue sequencer for a banked NTT/INTT/PWM datapath.
// Rev 1.0 -- initial release.
`default_nettype none

module polytop_seq #(
  parameter int N        = 256,
  parameter int P        = 8,
  parameter int STAGES   = 7,
  parameter int PIPE_LAT = 6,
  parameter int NPW      = 2,
  localparam int G  = N / (2 * P),
  localparam int IW = (G > 1) ? $clog2(G) : 1,
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     opcode,
  input  logic [NPW-1:0] num_poly,
  input  logic           stall,
  input  logic           abort,
  output logic [IW-1:0]  i,
  output logic [SW-1:0]  s,
  output logic [NPW-1:0] pidx,
  output logic           ren,
  output logic           en,
  output logic           wen,
  output logic [IW-1:0]  wi,
  output logic [SW-1:0]  ws,
  output logic           busy,
  output logic           finish,
  output logic           err
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_PWM = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  i_q, i_d;
  logic [SW-1:0]  s_q, s_d;
  logic [NPW-1:0] pidx_q, pidx_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;
  logic [SW-1:0]  last_s_q, last_s_d;
  logic [NPW-1:0] last_p_q, last_p_d;
  logic           err_q, err_d;

  logic [PIPE_LAT-1:0] vld_q;
  logic [IW-1:0]       wi_q [PIPE_LAT];
  logic [SW-1:0]       ws_q [PIPE_LAT];

  logic w_issue;

  assign w_issue = (state_q == ST_RUN) && !stall && !abort;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    s_d      = s_q;
    pidx_d   = pidx_q;
    dcnt_d   = dcnt_q;
    last_s_d = last_s_q;
    last_p_d = last_p_q;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (opcode == OP_RSV) begin
            err_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
            i_d      = '0;
            s_d      = '0;
            pidx_d   = '0;
            // Store terminal values so the drain exit is a plain equality test.
            last_s_d = (opcode == OP_PWM) ? '0 : SW'(STAGES - 1);
            last_p_d = (num_poly == '0) ? '0 : num_poly - NPW'(1);
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (i_q == IW'(G - 1)) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end else begin
            i_d = i_q + IW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DW'(PIPE_LAT - 1)) begin
          if (s_q != last_s_q) begin
            state_d = ST_RUN;
            s_d     = s_q + SW'(1);
            i_d     = '0;
          end else if (pidx_q != last_p_q) begin
            state_d = ST_RUN;
            s_d     = '0;
            i_d     = '0;
            pidx_d  = pidx_q + NPW'(1);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      i_d     = '0;
      s_d     = '0;
      pidx_d  = '0;
      dcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      s_q      <= '0;
      pidx_q   <= '0;
      dcnt_q   <= '0;
      last_s_q <= '0;
      last_p_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      s_q      <= s_d;
      pidx_q   <= pidx_d;
      dcnt_q   <= dcnt_d;
      last_s_q <= last_s_d;
      last_p_q <= last_p_d;
      err_q    <= err_d;
    end
  end

  // Write-back tracker: shifts every cycle regardless of stall so bubbles reach wen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        wi_q[k] <= '0;
        ws_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= w_issue;
      wi_q[0]  <= i_q;
      ws_q[0]  <= s_q;
      for (int k = 1; k < PIPE_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        wi_q[k]  <= wi_q[k-1];
        ws_q[k]  <= ws_q[k-1];
      end
      if (abort) begin
        vld_q <= '0;
      end
    end
  end

  assign i      = i_q;
  assign s      = s_q;
  assign pidx   = pidx_q;
  assign ren    = w_issue;
  assign en     = w_issue;
  assign wen    = vld_q[PIPE_LAT-1];
  assign wi     = wi_q[PIPE_LAT-1];
  assign ws     = ws_q[PIPE_LAT-1];
  assign busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign finish = (state_q == ST_DONE) && !abort;
  assign err    = err_q;

endmodule

`default_nettype wire
